// File: rtl/gshare_pkg.sv
// gshare_pkg: shared defaults, 2-bit counter encodings, saturating update and FIFO entry type
package gshare_pkg;
  localparam int DEF_PC_W = 8;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_QDEPTH = 4;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [1:0] ctr;
    logic taken;
    logic mispred;
  } upd_t;
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic t);
    return t ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/gshare_upd_fifo.sv
// gshare_upd_fifo: synchronous FIFO, extra-MSB pointers, push and pop allowed together even when full
module gshare_upd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/gshare_pht_arbiter.sv
// gshare_pht_arbiter: arbitrates one PHT port between gshare lookups and queued counter updates.
// Defining GSHARE_ARB_STATS_EN adds mispredict_count and stall_count outputs.
module gshare_pht_arbiter
  import gshare_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [1:0]       pred_ctr,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic [1:0]       res_ctr,
  input  logic             res_taken,
  input  logic             res_mispred,
  output logic             res_ready,
  output logic [IDX_W-1:0] pht_addr,
  output logic             pht_we,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata
`ifdef GSHARE_ARB_STATS_EN
  ,
  output logic [31:0]      mispredict_count,
  output logic [31:0]      stall_count
`endif
);
  localparam int EW = IDX_W + 4;
  logic [IDX_W-1:0] spec_ghr, arch_ghr, arch_nxt, idx, lk_idx, head_idx;
  logic [EW-1:0] head;
  logic [1:0] head_ctr;
  logic head_taken, head_mispred, full, empty, push, pop, upd_force, lk_v, unused_pc;
  assign unused_pc = ^pred_pc[PC_W-1:IDX_W];
  assign {head_idx, head_ctr, head_taken, head_mispred} = head;
  assign idx = pred_pc[IDX_W-1:0] ^ spec_ghr;
  // A lookup only gets the port when no write is issued, so it can never read a row being written
  assign upd_force = full || (!empty && head_mispred);
  assign pred_ready = !reset && pred_req && !upd_force;
  assign pop = !reset && !empty && (upd_force || !pred_req);
  assign res_ready = !reset && !full;
  assign push = res_valid && res_ready;
  assign arch_nxt = {arch_ghr[IDX_W-2:0], res_taken};
  assign pht_we = pop;
  assign pht_addr = reset ? '0 : pop ? head_idx : idx;
  assign pht_wdata = pop ? sat_ctr(head_ctr, head_taken) : 2'b00;
  assign pred_valid = lk_v;
  assign pred_ctr = lk_v ? pht_rdata : 2'b00;
  assign pred_taken = pred_ctr[1];
  assign pred_idx = lk_idx;
  gshare_upd_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({res_idx, res_ctr, res_taken, res_mispred}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // Mispredict repair takes priority over the speculative shift of a returning lookup
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
      lk_v <= 1'b0;
      lk_idx <= '0;
    end else begin
      lk_v <= pred_ready;
      if (pred_ready) lk_idx <= idx;
      if (push) arch_ghr <= arch_nxt;
      if (push && res_mispred) spec_ghr <= arch_nxt;
      else if (lk_v) spec_ghr <= {spec_ghr[IDX_W-2:0], pht_rdata[1]};
    end
`ifdef GSHARE_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mispredict_count <= '0;
      stall_count <= '0;
    end else begin
      if (push && res_mispred) mispredict_count <= mispredict_count + 32'd1;
      if (pred_req && !pred_ready) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_gshare_pht_arbiter.sv
// tb_gshare_pht_arbiter: directed table-driven bench with a behavioural single-port PHT
module tb_gshare_pht_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic pred_req = 0;
  logic [7:0] pred_pc = '0;
  logic pred_ready, pred_valid, pred_taken;
  logic [3:0] pred_idx;
  logic [1:0] pred_ctr;
  logic res_valid = 0;
  logic [3:0] res_idx = '0;
  logic [1:0] res_ctr = '0;
  logic res_taken = 0;
  logic res_mispred = 0;
  logic res_ready;
  logic [3:0] pht_addr;
  logic pht_we;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata = '0;
  logic [1:0] pht_mem [16];
  logic ld_en = 0;
  logic [3:0] ld_addr = '0;
  logic [1:0] ld_val = '0;
`ifdef GSHARE_ARB_STATS_EN
  logic [31:0] mispredict_count, stall_count;
`endif
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] idx;
    logic [1:0] ctr;
  } lk_t;
  typedef struct {
    logic [3:0] idx;
    logic [1:0] ctr;
    logic tk;
    logic [1:0] w;
  } up_t;
  lk_t lk_tab[10];
  up_t up_tab[8];

  gshare_pht_arbiter dut (
    .clk(clk),
    .reset(reset),
    .pred_req(pred_req),
    .pred_pc(pred_pc),
    .pred_ready(pred_ready),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_idx(pred_idx),
    .pred_ctr(pred_ctr),
    .res_valid(res_valid),
    .res_idx(res_idx),
    .res_ctr(res_ctr),
    .res_taken(res_taken),
    .res_mispred(res_mispred),
    .res_ready(res_ready),
    .pht_addr(pht_addr),
    .pht_we(pht_we),
    .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata)
`ifdef GSHARE_ARB_STATS_EN
    ,
    .mispredict_count(mispredict_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) pht_mem[ld_addr] <= ld_val;
    else if (pht_we) pht_mem[pht_addr] <= pht_wdata;
    pht_rdata <= pht_mem[pht_addr];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [1:0] v);
    ld_en = 1;
    ld_addr = a;
    ld_val = v;
    nxt();
    ld_en = 0;
  endtask

  task automatic push_res(input logic [3:0] i, input logic [1:0] c, input logic t, input logic m);
    res_valid = 1;
    res_idx = i;
    res_ctr = c;
    res_taken = t;
    res_mispred = m;
  endtask

  task automatic do_update(input logic [3:0] i, input logic [1:0] c, input logic t, input logic [1:0] w);
    pred_req = 0;
    push_res(i, c, t, 0);
    @(negedge clk);
    chk("upd_res_ready", res_ready, 1);
    nxt();
    res_valid = 0;
    @(negedge clk);
    chk("upd_we", pht_we, 1);
    chk("upd_addr", pht_addr, i);
    chk("upd_wdata", pht_wdata, w);
    nxt();
  endtask

  task automatic do_lookup(input logic [7:0] pc, input logic [3:0] i, input logic [1:0] c);
    pred_req = 1;
    pred_pc = pc;
    @(negedge clk);
    chk("lk_ready", pred_ready, 1);
    chk("lk_addr", pht_addr, i);
    chk("lk_we", pht_we, 0);
    nxt();
    pred_req = 0;
    @(negedge clk);
    chk("lk_valid", pred_valid, 1);
    chk("lk_idx", pred_idx, i);
    chk("lk_ctr", pred_ctr, c);
    chk("lk_taken", pred_taken, c[1]);
    nxt();
  endtask

  initial begin
    lk_tab[0] = '{8'h05, 4'h5, 2'b01};
    lk_tab[1] = '{8'h09, 4'h9, 2'b11};
    lk_tab[2] = '{8'h07, 4'h6, 2'b10};
    lk_tab[3] = '{8'h0A, 4'h9, 2'b11};
    lk_tab[4] = '{8'hF0, 4'h7, 2'b01};
    lk_tab[5] = '{8'h00, 4'hE, 2'b01};
    lk_tab[6] = '{8'h05, 4'h9, 2'b11};
    lk_tab[7] = '{8'h0C, 4'h5, 2'b01};
    lk_tab[8] = '{8'h0B, 4'h9, 2'b11};
    lk_tab[9] = '{8'h0C, 4'h9, 2'b11};
    up_tab[0] = '{4'h0, 2'b00, 1'b1, 2'b01};
    up_tab[1] = '{4'h1, 2'b01, 1'b1, 2'b10};
    up_tab[2] = '{4'h2, 2'b10, 1'b1, 2'b11};
    up_tab[3] = '{4'h3, 2'b11, 1'b1, 2'b11};
    up_tab[4] = '{4'h4, 2'b00, 1'b0, 2'b00};
    up_tab[5] = '{4'h5, 2'b01, 1'b0, 2'b00};
    up_tab[6] = '{4'h6, 2'b10, 1'b0, 2'b01};
    up_tab[7] = '{4'h7, 2'b11, 1'b0, 2'b10};
    pred_req = 1;
    pred_pc = 8'h05;
    #1;
    for (int i = 0; i < 16; i++) preload(4'(i), 2'b01);
    preload(4'h9, 2'b11);
    preload(4'h6, 2'b10);
    @(negedge clk);
    chk("rst_pred_ready", pred_ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_idx", pred_idx, 0);
    chk("rst_pred_ctr", pred_ctr, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_pht_we", pht_we, 0);
    chk("rst_pht_addr", pht_addr, 0);
    chk("rst_pht_wdata", pht_wdata, 0);
    nxt();
    pred_req = 0;
    reset = 0;
    // arch_ghr -> 0001 -> 0010; rows 0 and 1 are not read later
    do_update(4'h0, 2'b01, 1, 2'b10);
    do_update(4'h1, 2'b01, 0, 2'b00);
    for (int i = 0; i < 10; i++) do_lookup(lk_tab[i].pc, lk_tab[i].idx, lk_tab[i].ctr);
    // spec_ghr=1011, arch_ghr=0010: taken mispredict repairs spec to 0101
    push_res(4'h2, 2'b01, 1, 1);
    @(negedge clk);
    chk("mp_res_ready", res_ready, 1);
    nxt();
    res_valid = 0;
    pred_req = 1;
    pred_pc = 8'h00;
    @(negedge clk);
    chk("mp_head_ready", pred_ready, 0);
    chk("mp_head_we", pht_we, 1);
    chk("mp_head_addr", pht_addr, 4'h2);
    chk("mp_head_wdata", pht_wdata, 2'b10);
    nxt();
    @(negedge clk);
    chk("mp_lk_ready", pred_ready, 1);
    chk("mp_lk_addr", pht_addr, 4'h5);
    nxt();
    pred_req = 0;
    @(negedge clk);
    chk("mp_lk_idx", pred_idx, 4'h5);
    nxt();
    // ghr now 1010, arch 0101; mispredict in the cycle a lookup returns drops its shift
    pred_req = 1;
    @(negedge clk);
    chk("mp2_lk_addr", pht_addr, 4'hA);
    nxt();
    pred_req = 0;
    push_res(4'h3, 2'b00, 0, 1);
    @(negedge clk);
    chk("mp2_valid", pred_valid, 1);
    chk("mp2_idx", pred_idx, 4'hA);
    nxt();
    res_valid = 0;
    pred_req = 1;
    @(negedge clk);
    chk("mp2_head_ready", pred_ready, 0);
    nxt();
    @(negedge clk);
    chk("mp2_repair_addr", pht_addr, 4'hA);
    nxt();
    pred_req = 0;
    nxt();
    for (int i = 0; i < 8; i++) do_update(up_tab[i].idx, up_tab[i].ctr, up_tab[i].tk, up_tab[i].w);
    preload(4'h3, 2'b10);
    for (int i = 0; i < 3; i++) do_update(4'h3, pht_mem[3], 1, 2'b11);
    preload(4'h3, 2'b01);
    for (int i = 0; i < 3; i++) do_update(4'h3, pht_mem[3], 0, 2'b00);
    // Fill the FIFO while lookups keep winning the port
    pred_req = 1;
    pred_pc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      push_res(4'(4 + i), 2'b01, 1, 0);
      @(negedge clk);
      chk("fill_res_ready", res_ready, 1);
      chk("fill_pred_ready", pred_ready, 1);
      nxt();
    end
    res_valid = 0;
    @(negedge clk);
    chk("full_res_ready", res_ready, 0);
    chk("full_pred_ready", pred_ready, 0);
    chk("full_we", pht_we, 1);
    chk("full_addr", pht_addr, 4'h4);
    chk("full_wdata", pht_wdata, 2'b10);
    nxt();
    @(negedge clk);
    chk("after_full_ready", pred_ready, 1);
    chk("after_full_we", pht_we, 0);
    chk("after_full_res_ready", res_ready, 1);
    nxt();
    pred_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_we", pht_we, 1);
      chk("drain_addr", pht_addr, 4'(5 + i));
      nxt();
    end
    @(negedge clk);
    chk("drained_we", pht_we, 0);
    reset = 1;
    nxt();
    reset = 0;
    // RAW: mispredict write to row 7 (spec becomes 0001) collides with lookup pc=6 -> idx 7
    push_res(4'h7, 2'b01, 1, 1);
    nxt();
    res_valid = 0;
    pred_req = 1;
    pred_pc = 8'h06;
    @(negedge clk);
    chk("raw_ready", pred_ready, 0);
    chk("raw_we", pht_we, 1);
    chk("raw_addr", pht_addr, 4'h7);
    chk("raw_wdata", pht_wdata, 2'b10);
    nxt();
    @(negedge clk);
    chk("raw_retry_ready", pred_ready, 1);
    chk("raw_retry_addr", pht_addr, 4'h7);
    nxt();
    pred_req = 0;
    @(negedge clk);
    chk("raw_valid", pred_valid, 1);
    chk("raw_idx", pred_idx, 4'h7);
    chk("raw_ctr", pred_ctr, 2'b10);
    nxt();
    // Queue 3 entries behind lookups, then reset mid-cycle
    pred_req = 1;
    pred_pc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      push_res(4'(i), 2'b01, 0, 0);
      nxt();
    end
    res_valid = 0;
    #2;
    reset = 1;
    @(negedge clk);
    chk("mrst_we", pht_we, 0);
    chk("mrst_res_ready", res_ready, 0);
    chk("mrst_pred_ready", pred_ready, 0);
    chk("mrst_pred_valid", pred_valid, 0);
    chk("mrst_addr", pht_addr, 0);
    nxt();
    reset = 0;
    pred_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_we", pht_we, 0);
      chk("post_rst_res_ready", res_ready, 1);
      nxt();
    end
`ifdef GSHARE_ARB_STATS_EN
    chk("stats_mispredict", mispredict_count, 0);
    chk("stats_stall", stall_count, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
